// File: rtl/ram_bridge.sv
// Word-access bridge from a valid/ready requester to a synchronous single-port RAM.
// Define RAM_BRIDGE_RMW_EN to service partial writes by read-modify-write; otherwise they are rejected.
module ram_bridge (
  input  logic        clock,
  input  logic        resetN,
  input  logic        valid,
  input  logic        write,
  input  logic [16:0] address,
  input  logic [3:0]  writeStrobe,
  input  logic [31:0] writeData,
  output logic        ready,
  output logic [31:0] readData,
  output logic        writeError,
  output logic        ramWriteEnable,
  output logic [14:0] ramAddress,
  output logic [31:0] ramWriteData,
  input  logic [31:0] ramReadData
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESPOND} state_t;

  state_t     state;
  logic       is_write;
  logic [3:0] strobe;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  assign ramWriteEnable = (state == WRITE);
  assign ready          = (state == RESPOND);

`ifdef RAM_BRIDGE_RMW_EN
  assign writeError = 1'b0;
`else
  logic error;
  assign writeError = ready & error;
`endif

  // ramWriteData doubles as the latched write data; MERGE overwrites only the unstrobed bytes.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      ramAddress   <= '0;
      ramWriteData <= '0;
      readData     <= '0;
      is_write     <= 1'b0;
      strobe       <= '0;
`ifndef RAM_BRIDGE_RMW_EN
      error        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            ramAddress   <= address[16:2];
            ramWriteData <= writeData;
            is_write     <= write;
            strobe       <= writeStrobe;
`ifndef RAM_BRIDGE_RMW_EN
            error        <= 1'b0;
`endif
            if (!write)
              state <= READ;
            else if (writeStrobe == '1)
              state <= WRITE;
            else if (writeStrobe == '0)
              state <= RESPOND;
            else begin
`ifdef RAM_BRIDGE_RMW_EN
              state <= READ;
`else
              state <= RESPOND;
              error <= 1'b1;
`endif
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          if (is_write) begin
            for (int unsigned b = 0; b < 4; b++)
              if (!strobe[b])
                ramWriteData[8*b +: 8] <= ramReadData[8*b +: 8];
            state <= WRITE;
          end else begin
            readData <= ramReadData;
            state    <= RESPOND;
          end
        end
        WRITE:   state <= RESPOND;
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_bridge.md
RAM_BRIDGE -- requirements
Module: ram_bridge

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clock input, resetN input.
REQ-002 clock  input  1  rising-edge clock for all state, shared with the RAM.
REQ-003 resetN  input  1  asynchronous active-low reset.
REQ-004 valid  input  1  requester holds a transaction request until ready.
REQ-005 write  input  1  1 = write, 0 = read; sampled with valid.
REQ-006 address  input  17  byte address; bits [1:0] ignored, bits [16:2] select the word.
REQ-007 writeStrobe  input  4  byte enables; bit n selects writeData[8n+7:8n].
REQ-008 writeData  input  32  write data.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 readData  output  32  read result; valid while ready=1 for reads, held until the next read completes.
REQ-011 writeError  output  1  qualified by ready; partial write rejected.
REQ-012 ramWriteEnable  output  1  RAM write strobe.
REQ-013 ramAddress  output  15  RAM word address.
REQ-014 ramWriteData  output  32  word to RAM.
REQ-015 ramReadData  input  32  RAM output; valid the cycle after a read address is presented with ramWriteEnable=0.

Function
REQ-016 SHALL implement FSM states IDLE, READ, MERGE, WRITE, RESPOND.
REQ-017 IDLE: on valid=1, SHALL latch address[16:2], write, writeStrobe, writeData and transition as follows: read -> READ; write with strobe 4'b1111 -> WRITE; write with strobe 4'b0000 -> RESPOND with no RAM access; any other write -> READ.
REQ-018 ramAddress SHALL equal the latched word address in every non-IDLE state and SHALL hold its last value in IDLE.
REQ-019 READ SHALL last exactly one cycle with ramWriteEnable=0, then go to MERGE.
REQ-020 MERGE on a read SHALL load readData <= ramReadData and go to RESPOND.
REQ-021 MERGE on a partial write SHALL load ramWriteData with ramReadData bytes where the strobe bit is 0 and writeData bytes where it is 1, then go to WRITE; readData SHALL remain unchanged.
REQ-022 WRITE SHALL assert ramWriteEnable=1 for exactly one cycle, then go to RESPOND; for a full write, ramWriteData SHALL equal the latched writeData.
REQ-023 RESPOND SHALL assert ready=1 for exactly one cycle, then go to IDLE.
REQ-024 ramWriteEnable SHALL be 1 only in WRITE, decoded directly from the state register.
REQ-025 Latency, counted in cycles from the valid-sampling edge to ready=1:
- read: 3;
- full write: 2;
- partial write: 4;
- zero-strobe write: 1.
REQ-026 valid SHALL be sampled only in IDLE. Request inputs changing mid-transaction SHALL have no effect. valid still high in the cycle after RESPOND SHALL start a new transaction.
REQ-027 Back-to-back transactions SHALL have no dead cycles beyond the single IDLE cycle.

Reset
REQ-028 resetN=0 SHALL immediately force:
- state = IDLE;
- ready, writeError, ramWriteEnable = 0;
- ramAddress = 0;
- ramWriteData, readData = 0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction with no RAM write after assertion and no ready pulse.

Configuration
REQ-030 Macro RAM_BRIDGE_RMW_EN defined: partial writes SHALL follow REQ-017/021 (read-modify-write), and writeError SHALL be constant 0.
REQ-031 Macro RAM_BRIDGE_RMW_EN undefined: READ and MERGE SHALL be used for reads only. A partial write SHALL go IDLE -> RESPOND with no RAM access, with writeError=1 during that ready cycle; writeError SHALL be 0 for every other response.

Verification
REQ-032 Full write addr 0x00010, data 0xDEADBEEF, strobe 1111, then read 0x00010 -> one ramWriteEnable pulse at ramAddress 0x0004; read ready 3 cycles after valid with readData=0xDEADBEEF.
REQ-033 (RMW_EN) Word 0x0004 = 0x11223344; write 0xAABBCCDD with strobe 0101 -> ramWriteData=0x11BB33DD during WRITE; ready at cycle 4; a subsequent read returns 0x11BB33DD.
REQ-034 (no RMW_EN) Same partial write -> no ramWriteEnable pulse; ready after 1 cycle with writeError=1; a subsequent read returns 0x11223344.
REQ-035 Write with strobe 0000 -> ready after 1 cycle, ramWriteEnable never asserted, writeError=0.
REQ-036 resetN pulled low during MERGE of a partial write -> ramWriteEnable stays 0, no ready pulse, all outputs 0; the first transaction after release completes normally.
REQ-037 valid held high across 3 consecutive reads of 0x0, 0x4, 0x8 -> exactly 3 ready pulses, each 4 cycles apart, with the correct readData each.
